// File: rtl/gpio_filter_pkg.sv
// Shared limits and helpers for the GPIO deglitch filter bank.
package gpio_filter_pkg;

  localparam int MAX_DEPTH = 255;
  localparam int MAX_SYNC  = 3;

  // Run-length counter width able to hold 0..depth.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/gpio_filter_chan.sv
// One deglitch channel: optional sync chain, run-length qualifier,
// filtered level, registered edge pulses and sticky glitch flag.
module gpio_filter_chan
  import gpio_filter_pkg::*;
#(
  parameter int   DEPTH       = 2,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_BIT     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic din,
  input  logic glitch_clr,
  output logic dout,
  output logic pos_edge,
  output logic neg_edge,
  output logic glitch,
  output logic edge_src
);

  localparam int                CNT_W    = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             at_last;
  logic             take;
  logic             abort;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Synchroniser chain, free-running on every clk regardless of ena.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= {SYNC_STAGES{RST_BIT}};
        end else begin
          sync_q[0] <= din;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Qualifier decode: commit on the DEPTH-th differing sample, abort when
  // a partial run is interrupted by an agreeing sample.
  always_comb begin
    differ  = s ^ dout;
    at_last = (cnt == CNT_LAST);
    take    = ena & differ & at_last;
    abort   = ena & ~differ & (cnt != '0);
  end

  assign edge_src = take;

  // Run-length counter and filtered level; both hold while ena is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= RST_BIT;
    end else if (ena) begin
      if (!differ) begin
        cnt <= '0;
      end else if (at_last) begin
        dout <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Single-cycle edge pulses aligned with the dout change; sticky glitch
  // flag where a new abort beats a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      glitch   <= 1'b0;
    end else begin
      pos_edge <= take & s;
      neg_edge <= take & ~s;
      glitch   <= abort | (glitch & ~glitch_clr);
    end
  end

endmodule

// File: rtl/gpio_filter_bank.sv
// Bank of independent GPIO deglitch channels plus a shared any_edge strobe.
module gpio_filter_bank
  import gpio_filter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_LEVEL   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] glitch_clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] glitch,
  output logic             any_edge
);

  logic [WIDTH-1:0] edge_src;

  generate
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("gpio_filter_bank: DEPTH out of range 1..255");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
      $error("gpio_filter_bank: SYNC_STAGES out of range 0..3");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      gpio_filter_chan #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .RST_BIT     (RST_LEVEL[i])
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .din        (din[i]),
        .glitch_clr (glitch_clr[i]),
        .dout       (dout[i]),
        .pos_edge   (pos_edge[i]),
        .neg_edge   (neg_edge[i]),
        .glitch     (glitch[i]),
        .edge_src   (edge_src[i])
      );
    end
  endgenerate

  // any_edge is registered from the pre-register edge sources so it lines
  // up with the per-channel pulses instead of trailing them by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_edge <= 1'b0;
    else       any_edge <= |edge_src;
  end

endmodule

// File: tb/tb_gpio_filter_bank.sv
// Bench: four filter-bank configurations on shared stimulus, checked
// against a run-length reference model plus directed timing checks.
module tb_gpio_filter_bank;

  localparam int NI = 4;
  localparam int DEP [NI] = '{2, 4, 3, 1};
  localparam int SYN [NI] = '{2, 2, 1, 0};
  localparam logic [7:0] RSTL [NI] = '{8'hFF, 8'hFF, 8'hA5, 8'h0F};

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [7:0] din;
  logic [7:0] glitch_clr;

  logic [7:0] dout_o [NI];
  logic [7:0] pos_o  [NI];
  logic [7:0] neg_o  [NI];
  logic [7:0] gl_o   [NI];
  logic       any_o  [NI];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_dout [NI];
  logic [7:0] m_pe   [NI];
  logic [7:0] m_ne   [NI];
  logic [7:0] m_gl   [NI];
  logic       m_any  [NI];
  logic [7:0] m_sync [NI][3];
  int         m_run  [NI][8];

  always #5 clk = ~clk;

  gpio_filter_bank #(.WIDTH(8), .DEPTH(2), .SYNC_STAGES(2), .RST_LEVEL(8'hFF)) u_d2s2 (
    .clk(clk), .reset(reset), .ena(ena), .din(din), .glitch_clr(glitch_clr),
    .dout(dout_o[0]), .pos_edge(pos_o[0]), .neg_edge(neg_o[0]), .glitch(gl_o[0]), .any_edge(any_o[0]));
  gpio_filter_bank #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .RST_LEVEL(8'hFF)) u_d4s2 (
    .clk(clk), .reset(reset), .ena(ena), .din(din), .glitch_clr(glitch_clr),
    .dout(dout_o[1]), .pos_edge(pos_o[1]), .neg_edge(neg_o[1]), .glitch(gl_o[1]), .any_edge(any_o[1]));
  gpio_filter_bank #(.WIDTH(8), .DEPTH(3), .SYNC_STAGES(1), .RST_LEVEL(8'hA5)) u_d3s1 (
    .clk(clk), .reset(reset), .ena(ena), .din(din), .glitch_clr(glitch_clr),
    .dout(dout_o[2]), .pos_edge(pos_o[2]), .neg_edge(neg_o[2]), .glitch(gl_o[2]), .any_edge(any_o[2]));
  gpio_filter_bank #(.WIDTH(8), .DEPTH(1), .SYNC_STAGES(0), .RST_LEVEL(8'h0F)) u_d1s0 (
    .clk(clk), .reset(reset), .ena(ena), .din(din), .glitch_clr(glitch_clr),
    .dout(dout_o[3]), .pos_edge(pos_o[3]), .neg_edge(neg_o[3]), .glitch(gl_o[3]), .any_edge(any_o[3]));

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s inst%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_dout[k] = RSTL[k];
      m_pe[k] = '0; m_ne[k] = '0; m_gl[k] = '0; m_any[k] = 1'b0;
      for (int j = 0; j < 3; j++) m_sync[k][j] = RSTL[k];
      for (int c = 0; c < 8; c++) m_run[k][c] = 0;
    end
  endtask

  // Level moves once DEPTH consecutive enabled samples disagree with it;
  // an agreeing sample after a partial run records a glitch.
  task automatic model_step();
    logic [7:0] s;
    logic       ab;
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (SYN[k] == 0) s = din;
        else             s = m_sync[k][SYN[k]-1];
        for (int j = 2; j > 0; j--) m_sync[k][j] = m_sync[k][j-1];
        m_sync[k][0] = din;
        m_pe[k] = '0;
        m_ne[k] = '0;
        for (int c = 0; c < 8; c++) begin
          ab = 1'b0;
          if (ena) begin
            if (s[c] == m_dout[k][c]) begin
              ab = (m_run[k][c] > 0);
              m_run[k][c] = 0;
            end else begin
              m_run[k][c]++;
              if (m_run[k][c] == DEP[k]) begin
                m_dout[k][c] = s[c];
                m_run[k][c]  = 0;
                m_pe[k][c]   = s[c];
                m_ne[k][c]   = ~s[c];
              end
            end
          end
          m_gl[k][c] = ab | (m_gl[k][c] & ~glitch_clr[c]);
        end
        m_any[k] = |(m_pe[k] | m_ne[k]);
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk("dout", k, dout_o[k], m_dout[k]);
      chk("pos_edge", k, pos_o[k], m_pe[k]);
      chk("neg_edge", k, neg_o[k], m_ne[k]);
      chk("glitch", k, gl_o[k], m_gl[k]);
      chk("any_edge", k, 8'(any_o[k]), 8'(m_any[k]));
    end
  endtask

  // one clk: model advances on the rising edge, outputs sampled on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ena = 1'b1; din = 8'hFF; glitch_clr = '0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_dout", 0, dout_o[0], 8'hFF);
    chk("rst_dout", 2, dout_o[2], 8'hA5);
    chk("rst_pulses", 0, pos_o[0] | neg_o[0] | gl_o[0], 8'h00);
    chk("rst_any", 0, 8'(any_o[0]), 8'h00);
    repeat (2) cycle();
    reset = 1'b0;

    // release: no edge for 10 cycles
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("rel_edge", 0, pos_o[0] | neg_o[0], 8'h00);
      chk("rel_edge", 1, pos_o[1] | neg_o[1], 8'h00);
      chk("rel_any", 0, 8'(any_o[0]), 8'h00);
    end

    // clean step on din[0]: dout falls on the 4th edge, 1-cycle pulse
    din[0] = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      cycle();
      if (e < 4) chk("step_hold", 0, 8'(dout_o[0][0]), 8'h01);
    end
    chk("step_dout", 0, 8'(dout_o[0][0]), 8'h00);
    chk("step_neg", 0, neg_o[0], 8'h01);
    chk("step_any", 0, 8'(any_o[0]), 8'h01);
    chk("step_glitch", 0, 8'(gl_o[0][0]), 8'h00);
    cycle();
    chk("step_neg_w", 0, neg_o[0], 8'h00);
    chk("step_any_w", 0, 8'(any_o[0]), 8'h00);
    repeat (3) cycle();

    // short glitch against DEPTH=4: three low samples then high
    din[3] = 1'b0;
    repeat (3) cycle();
    din[3] = 1'b1;
    repeat (6) cycle();
    chk("sg_dout", 1, 8'(dout_o[1][3]), 8'h01);
    chk("sg_glitch", 1, 8'(gl_o[1][3]), 8'h01);
    glitch_clr[3] = 1'b1;
    cycle();
    glitch_clr[3] = 1'b0;
    chk("sg_clr", 1, 8'(gl_o[1][3]), 8'h00);
    repeat (4) cycle();

    // gated sampling, ena 1-in-5: rises on the 2nd tick after sync
    din[1] = 1'b0;
    repeat (8) cycle();
    din[1] = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      ena = (n % 5 == 0);
      cycle();
      if (n == 9)  chk("gate_hold", 0, 8'(dout_o[0][1]), 8'h00);
      if (n == 10) chk("gate_rise", 0, 8'(dout_o[0][1]), 8'h01);
      if (n == 10) chk("gate_pos", 0, pos_o[0], 8'h02);
      if (n == 11) chk("gate_pos_w", 0, pos_o[0], 8'h00);
    end
    ena = 1'b1;
    repeat (4) cycle();

    // simultaneous falls on channels 2 and 5
    din[2] = 1'b0; din[5] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      cycle();
      if (e == 3) chk("sim_any_pre", 0, 8'(any_o[0]), 8'h00);
      if (e == 4) chk("sim_neg", 0, neg_o[0], 8'h24);
      if (e == 4) chk("sim_any", 0, 8'(any_o[0]), 8'h01);
      if (e == 5) chk("sim_any_w", 0, 8'(any_o[0]), 8'h00);
    end
    repeat (4) cycle();

    // clear held across a new abort: set wins
    din[2] = 1'b1; glitch_clr[2] = 1'b1;
    cycle();
    din[2] = 1'b0;
    repeat (3) cycle();
    chk("clr_vs_set", 1, 8'(gl_o[1][2]), 8'h01);
    chk("clr_vs_set", 0, 8'(gl_o[0][2]), 8'h01);
    glitch_clr[2] = 1'b0;
    cycle();
    chk("sticky", 1, 8'(gl_o[1][2]), 8'h01);
    repeat (4) cycle();

    // reset mid-count on the DEPTH=3 bank (cnt reaches 1 on channel 6)
    din[6] = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("mid_dout", 2, dout_o[2], 8'hA5);
    chk("mid_glitch", 2, gl_o[2], 8'h00);
    chk("mid_pulse", 2, pos_o[2] | neg_o[2], 8'h00);
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    chk("mid_rel", 2, pos_o[2] | neg_o[2], 8'h00);
    chk("mid_rel", 0, pos_o[0] | neg_o[0], 8'h00);
    chk("mid_rel_gl", 2, gl_o[2], 8'h00);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) din = din ^ (8'h01 << $urandom_range(7));
      ena        = ($urandom_range(3) != 0);
      glitch_clr = ($urandom_range(7) == 0) ? 8'($urandom) : 8'h00;
      reset      = ($urandom_range(149) == 0);
      cycle();
    end
    reset = 1'b0;
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
